uart_rx_parity_check: RTL



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_parity_check_if.sv | 35 +++
 rtl/uart_rx_sync.sv | 19 +
 rtl/uart_rx_parity_check.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default frame constants and
// the parity function also used by the transmit-side parity generator.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

  // Payloads narrower than 8 bits are zero-padded, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_parity_check_if.sv
// Receiver line/host bundle. The break_det signal exists only when
// UART_RX_BREAK_DETECT_EN is defined.
import uart_pkg::*;

interface uart_rx_parity_check_if #(
  parameter int DATA_BITS = UART_DATA_BITS
);
  logic                 rx_serial;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                 break_det;

  modport master (
    input  rx_serial,
    output data_out, data_valid, parity_err, frame_err, busy, break_det
  );
  modport slave (
    output rx_serial,
    input  data_out, data_valid, parity_err, frame_err, busy, break_det
  );
`else
  modport master (
    input  rx_serial,
    output data_out, data_valid, parity_err, frame_err, busy
  );
  modport slave (
    output rx_serial,
    input  data_out, data_valid, parity_err, frame_err, busy
  );
`endif
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX line; resets to the idle
// (high) level so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst) ff <= 2'b11;
    else      ff <= {ff[0], d};
  end

  assign q = ff[1];

endmodule

// File: rtl/uart_rx_parity_check.sv
// UART receiver: start, DATA_BITS LSB-first, parity, stop; reports parity and
// framing errors. UART_RX_BREAK_DETECT_EN adds break detection and a BREAK state.
import uart_pkg::*;

module uart_rx_parity_check #(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int PARITY_ODD   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_rx_parity_check_if.master   bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                 par_rx;
`endif

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx_serial),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      baud_cnt       <= '0;
      bit_idx        <= '0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.busy       <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      bus.break_det  <= 1'b0;
`endif
    end else begin
      bus.data_valid <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      bus.break_det  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            baud_cnt <= '0;
            bit_idx  <= '0;
            bus.busy <= 1'b1;
          end
        end
        START: begin
          if (baud_cnt == HALF_M1) begin
            baud_cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              // Start bit gone by mid-bit: treat as line noise.
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt       <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == LAST_IDX) state   <= PARITY;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt <= '0;
            par_bad  <= (rx_s != parity_bit(8'(shreg), PARITY_ODD != 0));
`ifdef UART_RX_BREAK_DETECT_EN
            par_rx   <= rx_s;
`endif
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == FULL_M1) begin
            // Leaving at stop mid-bit lets the next start edge land in the second half.
            baud_cnt       <= '0;
            bus.data_out   <= shreg;
            bus.data_valid <= 1'b1;
            bus.frame_err  <= ~rx_s;
            bus.parity_err <= par_bad;
`ifdef UART_RX_BREAK_DETECT_EN
            if (shreg == '0 && !par_rx && !rx_s) begin
              bus.break_det <= 1'b1;
              state         <= BREAK;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
`else
            state    <= IDLE;
            bus.busy <= 1'b0;
`endif
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_RX_BREAK_DETECT_EN
        BREAK: begin
          if (rx_s) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
`endif
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
